// File: rtl/cyclic_block_decoder.sv
// Serial cyclic-code decoder: LFSR syndrome, single-bit error search, MSB-first message out.
// Optional frame counters when CBD_ERR_COUNT_EN is defined.
module cyclic_block_decoder #(
  parameter int             N = 7,
  parameter int             K = 3,
  parameter logic [N-K:0]   G = 5'b10111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_bit,
  input  logic        in_sof,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_bit,
  input  logic        out_ready,
  output logic        out_last,
  output logic        out_corr,
  output logic        out_err,
  output logic [15:0] cnt_corr,
  output logic [15:0] cnt_err
);

  localparam int R  = N - K;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] NM1 = CW'(N - 1);
  localparam logic [CW-1:0] KM1 = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    SEARCH,
    SEND
  } state_t;

  state_t state, state_nx;

  logic [N-1:0]  frame;
  logic [R-1:0]  s;
  logic [R-1:0]  p;
  logic [CW-1:0] cnt;
  logic [CW-1:0] pos;
  logic          found;
  logic          corr;
  logic          err;

  logic [R:0]    st;
  logic [R:0]    pt;
  logic [R-1:0]  s_sh;
  logic [R-1:0]  p_nx;
  logic          acc_in;
  logic          hit;
  logic          any;
  logic [CW-1:0] fpos;
  logic          rx_last;
  logic          srch_last;
  logic          tx_last;

  // One-step polynomial reductions: append a bit / multiply by x, then mod G
  always_comb begin
    st = {s, in_bit};
    if (st[R]) st = st ^ G;
    pt = {p, 1'b0};
    if (pt[R]) pt = pt ^ G;
  end

  assign s_sh      = st[R-1:0];
  assign p_nx      = pt[R-1:0];
  assign acc_in    = in_valid && in_ready;
  assign hit       = !found && (p == s);
  assign any       = found || hit;
  assign fpos      = hit ? cnt : pos;
  assign rx_last   = (cnt == NM1);
  assign srch_last = (state == SEARCH) && (cnt == NM1);
  assign tx_last   = (cnt == KM1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_bit   = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (acc_in && in_sof) state_nx = RECV;
      end
      RECV: begin
        in_ready = 1'b1;
        if (acc_in && !in_sof && rx_last)
          state_nx = (s_sh == '0) ? SEND : SEARCH;
      end
      SEARCH: begin
        if (cnt == NM1) state_nx = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_bit   = frame[N-1];
        out_last  = tx_last;
        if (out_ready && tx_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= '0;
      s     <= '0;
      p     <= '0;
      cnt   <= '0;
      pos   <= '0;
      found <= 1'b0;
      corr  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_in && in_sof) begin
            frame <= N'(in_bit);
            s     <= R'(in_bit);
            cnt   <= CW'(1);
            corr  <= 1'b0;
            err   <= 1'b0;
          end
        end
        RECV: begin
          if (acc_in) begin
            if (in_sof) begin
              frame <= N'(in_bit);
              s     <= R'(in_bit);
              cnt   <= CW'(1);
            end else begin
              frame <= {frame[N-2:0], in_bit};
              s     <= s_sh;
              if (rx_last) begin
                cnt   <= '0;
                p     <= R'(1);
                found <= 1'b0;
                pos   <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
        end
        SEARCH: begin
          p <= p_nx;
          if (hit) begin
            found <= 1'b1;
            pos   <= cnt;
          end
          if (cnt == NM1) begin
            cnt  <= '0;
            corr <= any;
            err  <= !any;
            if (any) frame[fpos] <= ~frame[fpos];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            frame <= {frame[N-2:0], 1'b0};
            if (tx_last) begin
              cnt  <= '0;
              corr <= 1'b0;
              err  <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_corr = corr;
  assign out_err  = err;

`ifdef CBD_ERR_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr <= '0;
      cnt_err  <= '0;
    end else if (srch_last) begin
      if (any && cnt_corr != 16'hFFFF) cnt_corr <= cnt_corr + 16'd1;
      if (!any && cnt_err != 16'hFFFF) cnt_err <= cnt_err + 16'd1;
    end
  end
`else
  assign cnt_corr = '0;
  assign cnt_err  = '0;
`endif

endmodule

// File: tb/tb_cyclic_block_decoder.sv
// Bench for cyclic_block_decoder: directed frames, stalls, resets, random frames
// checked against a polynomial-division reference model.
module tb_cyclic_block_decoder;

  localparam int         N = 7;
  localparam int         K = 3;
  localparam int         R = N - K;
  localparam logic [R:0] G = 5'b10111;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_bit, in_sof, in_ready;
  logic        out_valid, out_bit, out_ready, out_last;
  logic        out_corr, out_err;
  logic [15:0] cnt_corr, cnt_err;

  int n_chk  = 0;
  int n_fail = 0;
  int m_corr = 0;
  int m_err  = 0;

  cyclic_block_decoder #(.N(N), .K(K), .G(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_corr  (out_corr),
    .out_err   (out_err),
    .cnt_corr  (cnt_corr),
    .cnt_err   (cnt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of v(x) divided by G(x) by plain long division
  function automatic logic [N-1:0] rem_of(input logic [N-1:0] v);
    logic [N-1:0] t;
    t = v;
    for (int d = N - 1; d >= R; d--)
      if (t[d]) t = t ^ (N'(G) << (d - R));
    return t;
  endfunction

  function automatic int exp_corr_cnt();
`ifdef CBD_ERR_COUNT_EN
    return m_corr;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_err_cnt();
`ifdef CBD_ERR_COUNT_EN
    return m_err;
`else
    return 0;
`endif
  endfunction

  task automatic send_word(input logic [N-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_bit   = w[N-1-i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic [N-1:0] w,
                           input int stall_bit, input int stall_len);
    logic [N-1:0] fixed, one;
    logic         e_corr, e_err;
    int           e_lat, c;
    one    = 1;
    fixed  = w;
    e_corr = 1'b0;
    e_err  = 1'b0;
    e_lat  = 1;
    if (rem_of(w) != '0) begin
      e_lat = N + 1;
      e_err = 1'b1;
      for (int i = 0; i < N; i++)
        if (!e_corr && rem_of(w ^ (one << i)) == '0) begin
          e_corr = 1'b1;
          e_err  = 1'b0;
          fixed  = w ^ (one << i);
        end
      if (e_corr) m_corr++;
      else        m_err++;
    end
    check({tag, ".rdy0"}, in_ready, 1);
    send_word(w, N);
    c = 0;
    while (!out_valid && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, ".lat"}, c + 1, e_lat);
    for (int j = 0; j < K; j++) begin
      check({tag, ".vld"}, out_valid, 1);
      check({tag, ".bit"}, out_bit, fixed[N-1-j]);
      check({tag, ".last"}, out_last, (j == K - 1));
      check({tag, ".corr"}, out_corr, e_corr);
      check({tag, ".err"}, out_err, e_err);
      check({tag, ".rdyS"}, in_ready, 0);
      if (j == stall_bit) begin
        out_ready = 1'b0;
        for (int t = 0; t < stall_len; t++) begin
          @(posedge clk); #1;
          check({tag, ".hv"}, out_valid, 1);
          check({tag, ".hb"}, out_bit, fixed[N-1-j]);
          check({tag, ".hl"}, out_last, (j == K - 1));
          check({tag, ".hr"}, in_ready, 0);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    check({tag, ".endv"}, out_valid, 0);
    check({tag, ".endr"}, in_ready, 1);
    check({tag, ".endc"}, out_corr, 0);
    check({tag, ".ende"}, out_err, 0);
    check({tag, ".cc"}, cnt_corr, exp_corr_cnt());
    check({tag, ".ce"}, cnt_err, exp_err_cnt());
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".ov"}, out_valid, 0);
    check({tag, ".ob"}, out_bit, 0);
    check({tag, ".ol"}, out_last, 0);
    check({tag, ".oc"}, out_corr, 0);
    check({tag, ".oe"}, out_err, 0);
    check({tag, ".cc"}, cnt_corr, 0);
    check({tag, ".ce"}, cnt_err, 0);
  endtask

  initial begin
    logic [N-1:0] cw, v, one;
    int           ne, sb;
    one       = 1;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst.rdy", in_ready, 1);
    check_reset_vals("rst");

    run_frame("clean", 7'b1011100, K, 0);
    run_frame("x6", 7'b0011100, K, 0);
    run_frame("x0", 7'b1011101, K, 0);
    run_frame("dbl", 7'b0111100, K, 0);
    run_frame("stall", 7'b1011100, 1, 5);

    send_word(7'b0110000, 4);
    run_frame("sof", 7'b1011100, K, 0);

    send_word(7'b1011100, N);
    check("mid.vld", out_valid, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("mid.rdy", in_ready, 1);
    check_reset_vals("mid");
    m_corr = 0;
    m_err  = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid.rdy2", in_ready, 1);
    check_reset_vals("mid2");
    run_frame("post", 7'b0011100, K, 0);

    for (int f = 0; f < 24; f++) begin
      v  = N'($urandom_range(0, (1 << K) - 1)) << R;
      cw = v ^ rem_of(v);
      ne = $urandom_range(0, 2);
      for (int e = 0; e < ne; e++) cw = cw ^ (one << $urandom_range(0, N - 1));
      sb = $urandom_range(0, K);
      run_frame("rnd", cw, sb, $urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
